// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage.
// Operand slices shift down each stage while sum slices accumulate upward.
module rca_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int OW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [OW-1:0]    a_i;
    logic [OW-1:0]    b_i;
    logic             c_i;
    logic             v_i;
    logic [CHUNK-1:0] sl;
    logic             c_t;
    logic [SW-1:0]    s_n;
    logic [SW-1:0]    s_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_src
      assign a_i = A;
      assign b_i = B ^ {WIDTH{sub}};
      assign c_i = C_in ^ sub;
      assign v_i = in_valid;
      assign s_n = sl;
    end else begin : g_src
      assign a_i = g_st[k-1].g_fw.a_r;
      assign b_i = g_st[k-1].g_fw.b_r;
      assign c_i = g_st[k-1].c_r;
      assign v_i = g_st[k-1].v_r;
      assign s_n = {sl, g_st[k-1].s_r};
    end

    always_comb begin
      sl  = '0;
      c_t = c_i;
      for (int i = 0; i < CHUNK; i++) begin
        sl[i] = a_i[i] ^ b_i[i] ^ c_t;
        c_t   = (a_i[i] & b_i[i]) |
                (c_t & (a_i[i] ^ b_i[i]));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        s_r <= '0;
        c_r <= 1'b0;
      end else if (advance) begin
        v_r <= v_i;
        s_r <= s_n;
        c_r <= c_t;
      end
    end

    // Only the not-yet-consumed operand bits travel on.
    if (k < STAGES - 1) begin : g_fw
      logic [OW-CHUNK-1:0] a_r;
      logic [OW-CHUNK-1:0] b_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_i[OW-1:CHUNK];
          b_r <= b_i[OW-1:CHUNK];
        end
      end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    if (k == STAGES - 1) begin : g_last
      logic ov_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ov_r <= 1'b0;
        end else if (advance) begin
          ov_r <= a_i[CHUNK-1] ^ b_i[CHUNK-1] ^
                  sl[CHUNK-1] ^ c_t;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_r;
  assign S         = g_st[STAGES-1].s_r;
  assign C_out     = g_st[STAGES-1].c_r;
  assign overflow  = g_st[STAGES-1].g_last.ov_r;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed bench for rca_pipe_addsub (WIDTH=16, CHUNK=4).
// Checks latency, wrap, overflow, backpressure, reset flush, random ops.
module tb_rca_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        C_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [17:0] q[$];

  rca_pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .C_out(C_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // {overflow, C_out, S} from plain 17-bit arithmetic
  function automatic logic [17:0] ref_op(
    input logic [15:0] a, input logic [15:0] b,
    input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ov;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, ci ^ sb};
    ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb,
                         input logic [15:0] es,
                         input logic ec, input logic eo);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a; B = b; C_in = ci; sub = sb;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      chk({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_S"}, {16'd0, S}, {16'd0, es});
    chk({tag, "_C"}, {31'd0, C_out}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  // One cycle: consume/check output, then drive and log accepted input
  task automatic step(input logic v,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb,
                      input logic rdy);
    @(negedge clk);
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        chk("result", {14'd0, overflow, C_out, S},
            {14'd0, q.pop_front()});
        n_out++;
      end
    end
    in_valid = v;
    A = a; B = b; C_in = ci; sub = sb;
    #1;
    if (in_valid && in_ready) q.push_back(ref_op(a, b, ci, sb));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0; B = '0; C_in = 1'b0; sub = 1'b0;
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_S", {16'd0, S}, 32'd0);
    chk("rst_C", {31'd0, C_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    run_one("t1", 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_one("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("t3b", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("t3c", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("t3d", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_one("t3e", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

    // back-to-back: 8 ops, outputs on iterations 4..11
    @(negedge clk);
    base = n_out;
    for (int n = 0; n < 14; n++) begin
      if (n < 8)
        step(1'b1, 16'(n * 16'h2345), 16'hF00F, 1'(n >> 1), 1'(n), 1'b1);
      else
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t4_vld", {31'd0, out_valid}, {31'd0, (n >= 4 && n < 12)});
    end
    chk("t4_count", n_out - base, 32'd8);

    // stall while full
    base = n_out;
    for (int n = 0; n < 4; n++)
      step(1'b1, 16'(16'h1111 * (n + 1)), 16'h0F0F, 1'b0, 1'(n), 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0);
      chk("t5_rdy", {31'd0, in_ready}, 32'd0);
      chk("t5_vld", {31'd0, out_valid}, 32'd1);
      chk("t5_hold", {14'd0, overflow, C_out, S}, {14'd0, q[0]});
    end
    step(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_count", n_out - base, 32'd5);
    chk("t5_empty", q.size(), 32'd0);

    // reset with 3 ops in flight
    for (int n = 0; n < 3; n++)
      step(1'b1, 16'(16'h0101 << n), 16'h0033, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_flush", {31'd0, out_valid}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("t6_none", {31'd0, out_valid}, 32'd0);
    end

    // random ops with random backpressure
    base = n_out;
    for (int n = 0; n < 60; n++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    for (int n = 0; n < 12; n++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t7_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
